wb_ip_mailbox: RTL
==================

// Module: wb_ip_mailbox
// PURPOSE
//  IP-side register backend placed directly behind the Wishbone subordinate interface.
//  Consumes its IP request port (address/wdata/read_en/write_en) and returns rdata/ack/stall.
//  Implements a show-ahead word FIFO mailbox (push on write, pop on read) with level, flags and threshold.
//  Also drives the interface's status and irq inputs.
// PARAMETERS
//  WB_DATA_WIDTH              32  data word width, multiple of 8
//  WB_REGISTER_ADDRESS_WIDTH  16  width of byte offset from the interface
//  FIFO_DEPTH                 16  entries; power of 2, >=2
//  (local) LVL_W = $clog2(FIFO_DEPTH)+1
// PORTS
//  i_wb_clk       in   1    clock, shared with the interface
//  i_wb_rst_n     in   1    reset, asynchronous assert, active-low
//  i_ip_address   in   RAW  byte offset (RAW = WB_REGISTER_ADDRESS_WIDTH)
//  i_ip_wdata     in   DW   byte-lane-merged write data
//  i_ip_read_en   in   1    access request (also high during writes)
//  i_ip_write_en  in   1    write request
//  o_ip_rdata     out  DW   combinational read data for the addressed register
//  o_ip_ack       out  1    request accepted this cycle
//  o_ip_stall     out  1    request cannot be accepted this cycle
//  i_ip_control   in   DW   control reg; bit0 = FLUSH (level)
//  o_ip_status    out  DW   {.., full[LVL_W+1], empty[LVL_W], level[LVL_W-1:0]}
//  o_ip_irq       out  DW   bit0 level>=thresh, bit1 overflow flag, bit2 underflow flag, others 0
// BEHAVIOUR
//  Request decode:
//  - wr = i_ip_write_en; rd = i_ip_read_en & !i_ip_write_en.
//  - Commit only when (wr|rd) & !o_ip_stall.
//  - o_ip_ack = (wr|rd) & !o_ip_stall, combinational, same cycle. The interface registers the WB ack.
//  - Stall is pure combinational; a stalled request is re-presented unchanged and has no side effect.
//  - Address decode: the interconnect gates stb, so every request seen here is addressed to this core.
//  Register map (byte offsets):
//  - 0x20 DATA
//    - Write: push i_ip_wdata.
//    - Read: return head and pop. Read while empty returns 0, sets UNDERFLOW and does not stall.
//  - 0x24 LEVEL: read only, zero-extended count.
//  - 0x28 FLAGS: bit0 OVERFLOW, bit1 UNDERFLOW. Write-1-to-clear; a set event in the same cycle wins over the clear.
//  - 0x2C THRESH: RW, LVL_W bits, upper bits read 0.
//  - Any other offset >=0x20: ack, read 0, writes ignored.
//  Byte-lane merge: during a write, o_ip_rdata returns the addressed register's current value (DATA: head, no pop).
//  FIFO:
//  - Pointers carry an extra wrap bit.
//  - empty = ptrs equal; full = addresses equal and wrap bits differ.
//  - Head is read combinationally from mem[rd_ptr].
//  - Push and pop never coincide (one request per cycle).
//  - Level saturates naturally at FIFO_DEPTH; pointers wrap mod 2*FIFO_DEPTH.
//  FLUSH:
//  - While bit0 of i_ip_control is high: pointers are zeroed every cycle and pushes are discarded.
//  - Flags are kept. Acks and stalls are still generated normally.
//  Reset values:
//  - Pointers 0, flags 0, THRESH = FIFO_DEPTH/2, memory not reset.
//  - Outputs after reset: o_ip_status = empty only, o_ip_irq = 0, o_ip_ack = 0, o_ip_stall = 0.
//  - Reset asserted mid-transfer aborts it; the request is not committed.
//  Threshold IRQ: irq bit0 = (level >= THRESH) & (THRESH != 0). It is a level signal; the interface makes it sticky.
// CONFIGURATION
//  WB_MBOX_STALL_ON_FULL_EN defined:
//  - A DATA write while full raises o_ip_stall until a pop or flush frees space. OVERFLOW never sets.
//  WB_MBOX_STALL_ON_FULL_EN undefined:
//  - A DATA write while full is acked, dropped and sets OVERFLOW. o_ip_stall is constantly 0.
// STRUCTURE
//  Package wb_mbox_pkg holds:
//  - Offset constants MBOX_DATA/LEVEL/FLAGS/THRESH_OFS.
//  - Flag bit indices and IRQ bit indices.
//  - A typedef enum for the decoded access {ACC_NONE, ACC_DATA, ACC_LEVEL, ACC_FLAGS, ACC_THRESH, ACC_OTHER}.
//  Sub-module mbox_sync_fifo: parameterized FIFO with push/pop/flush, head, level, full, empty.
//  The top level holds decode, flags, THRESH and the status/irq mapping.
// TESTING
//  1. Reset, then 3 pushes (0xA1,0xB2,0xC3) at DATA:
//     ack each cycle; LEVEL reads 3; 3 DATA reads return 0xA1,0xB2,0xC3; empty=1.
//  2. Read DATA when empty:
//     rdata=0, ack=1, FLAGS=0x2, irq bit2=1.
//     Then write 0x2 to FLAGS: FLAGS=0 and irq bit2=0.
//  3. Push 16 words into a 16-deep FIFO, then a 17th:
//     - Macro defined: stall=1 with no ack; one DATA read releases the stall and 17th is stored, level=16.
//     - Macro undefined: 17th is acked, FLAGS bit0=1, level stays 16.
//  4. THRESH=4, pushes 1..4: irq bit0 rises exactly on the 4th push commit; one pop clears it.
//  5. Level 5, FLUSH=1 for one cycle with a concurrent push: level=0, push discarded, flags unchanged.
//  6. Level 2 with a read request in flight, assert i_wb_rst_n low asynchronously mid-cycle:
//     status goes to empty immediately, no pop is committed, flags=0.

Source files
------------

// File: rtl/wb_mbox_pkg.sv
// Package for the Wishbone IP mailbox: register offsets, flag and irq bit
// positions, the decoded-access enum and the offset decoder.
package wb_mbox_pkg;

    localparam int unsigned MBOX_DATA_OFS   = 32'h20;
    localparam int unsigned MBOX_LEVEL_OFS  = 32'h24;
    localparam int unsigned MBOX_FLAGS_OFS  = 32'h28;
    localparam int unsigned MBOX_THRESH_OFS = 32'h2C;

    localparam int FLAG_OVERFLOW  = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_W         = 2;

    localparam int IRQ_THRESH    = 0;
    localparam int IRQ_OVERFLOW  = 1;
    localparam int IRQ_UNDERFLOW = 2;

    typedef enum logic [2:0] {
        ACC_NONE,
        ACC_DATA,
        ACC_LEVEL,
        ACC_FLAGS,
        ACC_THRESH,
        ACC_OTHER
    } mbox_acc_e;

    // Map a byte offset to the register it selects; unknown offsets are
    // acked but behave as read-zero / write-ignore.
    function automatic mbox_acc_e mbox_decode(input logic [31:0] ofs);
        mbox_acc_e acc;
        acc = ACC_OTHER;
        case (ofs)
            MBOX_DATA_OFS:   acc = ACC_DATA;
            MBOX_LEVEL_OFS:  acc = ACC_LEVEL;
            MBOX_FLAGS_OFS:  acc = ACC_FLAGS;
            MBOX_THRESH_OFS: acc = ACC_THRESH;
            default:         acc = ACC_OTHER;
        endcase
        return acc;
    endfunction

endpackage

// File: rtl/wb_ip_mailbox_if.sv
// IP-side request/response bundle between the Wishbone subordinate interface
// (master modport) and the mailbox backend (slave modport).
interface wb_ip_mailbox_if #(
    parameter int DW = 32,
    parameter int AW = 16
);
    logic [AW-1:0] i_ip_address;
    logic [DW-1:0] i_ip_wdata;
    logic          i_ip_read_en;
    logic          i_ip_write_en;
    logic [DW-1:0] o_ip_rdata;
    logic          o_ip_ack;
    logic          o_ip_stall;
    logic [DW-1:0] i_ip_control;
    logic [DW-1:0] o_ip_status;
    logic [DW-1:0] o_ip_irq;

    modport master (
        output i_ip_address, i_ip_wdata, i_ip_read_en, i_ip_write_en, i_ip_control,
        input  o_ip_rdata, o_ip_ack, o_ip_stall, o_ip_status, o_ip_irq
    );

    modport slave (
        input  i_ip_address, i_ip_wdata, i_ip_read_en, i_ip_write_en, i_ip_control,
        output o_ip_rdata, o_ip_ack, o_ip_stall, o_ip_status, o_ip_irq
    );
endinterface

// File: rtl/mbox_sync_fifo.sv
// Show-ahead synchronous word FIFO with wrap-bit pointers, level, full/empty
// and a flush that zeroes both pointers and discards a concurrent push.
module mbox_sync_fifo #(
    parameter  int DW    = 32,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LVL_W = AW + 1
) (
    input  logic             i_wb_clk,
    input  logic             i_wb_rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [DW-1:0]    wdata,
    output logic [DW-1:0]    head,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] mem [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign level   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    // Pointer update: flush dominates, otherwise advance on accepted push/pop.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are only meaningful between the pointers.
    // NOTE: the memory array has no reset so it maps onto plain RAM/flops without reset fan-out.
    always_ff @(posedge i_wb_clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/wb_ip_mailbox.sv
// Wishbone IP-side mailbox backend: request decode, DATA/LEVEL/FLAGS/THRESH
// registers, status and irq mapping around a show-ahead word FIFO.
// Build option: define WB_MBOX_STALL_ON_FULL_EN to stall DATA writes while
// the FIFO is full instead of dropping them and raising OVERFLOW.
module wb_ip_mailbox
    import wb_mbox_pkg::*;
#(
    parameter  int WB_DATA_WIDTH             = 32,
    parameter  int WB_REGISTER_ADDRESS_WIDTH = 16,
    parameter  int FIFO_DEPTH                = 16,
    localparam int LVL_W                     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              i_wb_clk,
    input  logic              i_wb_rst_n,
    wb_ip_mailbox_if.slave    bus
);

    localparam int DW = WB_DATA_WIDTH;

    logic             wr;
    logic             rd;
    logic             stall;
    logic             commit;
    mbox_acc_e        acc;
    logic             flush;
    logic             fifo_push;
    logic             fifo_pop;
    logic [DW-1:0]    head;
    logic [LVL_W-1:0] level;
    logic             full;
    logic             empty;
    logic [FLAG_W-1:0] flags;
    logic [FLAG_W-1:0] flag_set;
    logic [FLAG_W-1:0] flag_clr;
    logic [LVL_W-1:0] thresh;
    logic [DW-1:0]    rdata;
    logic [DW-1:0]    status;
    logic [DW-1:0]    irq;
    logic             unused_ok;

    assign wr    = bus.i_ip_write_en;
    assign rd    = bus.i_ip_read_en && !bus.i_ip_write_en;
    assign flush = bus.i_ip_control[0];

    // Decode which register the current request addresses.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        acc = ACC_NONE;
        if (wr || rd) acc = mbox_decode(32'(bus.i_ip_address));
    end

`ifdef WB_MBOX_STALL_ON_FULL_EN
    assign stall = wr && (acc == ACC_DATA) && full;
`else
    assign stall = 1'b0;
`endif

    assign commit    = (wr || rd) && !stall;
    assign fifo_push = commit && wr && (acc == ACC_DATA);
    assign fifo_pop  = commit && rd && (acc == ACC_DATA);

    mbox_sync_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_wb_clk   (i_wb_clk),
        .i_wb_rst_n (i_wb_rst_n),
        .push       (fifo_push),
        .pop        (fifo_pop),
        .flush      (flush),
        .wdata      (bus.i_ip_wdata),
        .head       (head),
        .level      (level),
        .full       (full),
        .empty      (empty)
    );

    // Flag set events and write-1-to-clear mask for this cycle.
    always_comb begin
        flag_set = '0;
        flag_clr = '0;
`ifndef WB_MBOX_STALL_ON_FULL_EN
        flag_set[FLAG_OVERFLOW] = fifo_push && full;
`endif
        flag_set[FLAG_UNDERFLOW] = fifo_pop && empty;
        if (commit && wr && (acc == ACC_FLAGS)) flag_clr = bus.i_ip_wdata[FLAG_W-1:0];
    end

    // Sticky flags (set wins over clear) and the threshold register.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            flags  <= '0;
            thresh <= LVL_W'(FIFO_DEPTH / 2);
        end else begin
            flags <= (flags & ~flag_clr) | flag_set;
            if (commit && wr && (acc == ACC_THRESH)) thresh <= bus.i_ip_wdata[LVL_W-1:0];
        end
    end

    // Read mux; during writes it returns the current value for byte-lane merge.
    always_comb begin
        rdata = '0;
        case (acc)
            ACC_DATA:   if (!empty) rdata = head;
            ACC_LEVEL:  rdata[LVL_W-1:0]  = level;
            ACC_FLAGS:  rdata[FLAG_W-1:0] = flags;
            ACC_THRESH: rdata[LVL_W-1:0]  = thresh;
            default:    rdata = '0;
        endcase
    end

    // Status word and interrupt lines presented to the interface.
    always_comb begin
        status = '0;
        status[LVL_W-1:0] = level;
        status[LVL_W]     = empty;
        status[LVL_W+1]   = full;
        irq = '0;
        irq[IRQ_THRESH]    = (thresh != '0) && (level >= thresh);
        irq[IRQ_OVERFLOW]  = flags[FLAG_OVERFLOW];
        irq[IRQ_UNDERFLOW] = flags[FLAG_UNDERFLOW];
    end

    assign bus.o_ip_rdata  = rdata;
    assign bus.o_ip_ack    = commit;
    assign bus.o_ip_stall  = stall;
    assign bus.o_ip_status = status;
    assign bus.o_ip_irq    = irq;

    assign unused_ok = ^bus.i_ip_control[DW-1:1];

endmodule
